// File: rtl/quadrature_gen.sv
// PmodENC-style quadrature encoder emulator: turns accepted step commands into one
// Gray-coded A/B detent cycle each and tracks the signed position of emitted steps.
module quadrature_gen #(
    parameter int unsigned PHASE_TICKS = 4,
    parameter int unsigned POS_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 step_valid,
    input  logic                 step_left,
    output logic                 step_ready,
    output logic                 rotary_a,
    output logic                 rotary_b,
    output logic                 busy,
    output logic                 step_done,
    output logic [POS_WIDTH-1:0] position
);

    localparam int unsigned TICK_W = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PHASE_TICKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PH1,
        S_PH2,
        S_PH3,
        S_PH4
    } state_e;

    state_e                state_q, state_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic                  dir_q, dir_d;
    logic                  a_q, a_d;
    logic                  b_q, b_d;
    logic                  done_q, done_d;
    logic [POS_WIDTH-1:0]  pos_q, pos_d;
    logic                  phase_end;

    assign phase_end = (tick_q == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            pos_q   <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            pos_q   <= pos_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        pos_d   = pos_q;

        case (state_q)
            S_IDLE: begin
                if (step_valid) begin
                    state_d = S_PH1;
                    tick_d  = '0;
                    dir_d   = step_left;
                end
            end
            S_PH1, S_PH2, S_PH3, S_PH4: begin
                if (!phase_end) begin
                    tick_d = tick_q + TICK_W'(1);
                end else begin
                    tick_d = '0;
                    case (state_q)
                        S_PH1: begin
                            state_d = S_PH2;
                            // Count on the edge that drives 11, when a decoder registers the event.
                            pos_d   = dir_q ? (pos_q - POS_WIDTH'(1)) : (pos_q + POS_WIDTH'(1));
                        end
                        S_PH2:   state_d = S_PH3;
                        S_PH3:   state_d = S_PH4;
                        default: begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    // Outputs are registered, so decode the code from the next state.
    always_comb begin
        a_d = 1'b0;
        b_d = 1'b0;
        case (state_d)
            S_PH1: begin
                a_d = !dir_d;
                b_d = dir_d;
            end
            S_PH2: begin
                a_d = 1'b1;
                b_d = 1'b1;
            end
            S_PH3: begin
                a_d = dir_d;
                b_d = !dir_d;
            end
            default: begin
                a_d = 1'b0;
                b_d = 1'b0;
            end
        endcase
    end

    assign step_ready = (state_q == S_IDLE);
    assign busy       = !step_ready;
    assign rotary_a   = a_q;
    assign rotary_b   = b_q;
    assign step_done  = done_q;
    assign position   = pos_q;

endmodule

// File: tb/tb_quadrature_gen.sv
// Directed bench for quadrature_gen: timing of the A/B sequence, handshake, async reset,
// position wrap, plus a Gray-step monitor and a reference quadrature decoder model.
module tb_quadrature_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        step_valid, step_left;
    logic        step_ready, rotary_a, rotary_b, busy, step_done;
    logic [15:0] position;

    logic        sv_w, sl_w;
    logic        rdy_w, a_w, b_w, busy_w, done_w;
    logic [3:0]  pos_w;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned acc_cyc[$];
    logic        acc_dir[$];
    logic        ev_dir[$];
    logic [1:0]  prev_ba = 2'b00;
    int unsigned ev0;

    always #5 clk = ~clk;

    quadrature_gen #(.PHASE_TICKS(4), .POS_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .step_valid(step_valid), .step_left(step_left),
        .step_ready(step_ready), .rotary_a(rotary_a), .rotary_b(rotary_b),
        .busy(busy), .step_done(step_done), .position(position)
    );

    quadrature_gen #(.PHASE_TICKS(1), .POS_WIDTH(4)) dut_w (
        .clk(clk), .reset_n(reset_n), .step_valid(sv_w), .step_left(sl_w),
        .step_ready(rdy_w), .rotary_a(a_w), .rotary_b(b_w),
        .busy(busy_w), .step_done(done_w), .position(pos_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (step_valid && step_ready) begin
            acc_cyc.push_back(cyc);
            acc_dir.push_back(step_left);
        end
    end

    // Gray-step monitor and reference decoder: event when 11 is entered; 10 before 11 means left.
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ba = 2'b00;
        end else begin
            if ({rotary_b, rotary_a} != prev_ba) begin
                checks++;
                assert ($countones({rotary_b, rotary_a} ^ prev_ba) == 1) else begin
                    errors++;
                    $error("FAIL gray_step: observed %b->%b expected one bit change",
                           prev_ba, {rotary_b, rotary_a});
                end
                if ({rotary_b, rotary_a} == 2'b11)
                    ev_dir.push_back(prev_ba == 2'b10);
            end
            prev_ba = {rotary_b, rotary_a};
        end
    end

    task automatic w_step(input logic dir);
        sv_w = 1'b1;
        sl_w = dir;
        adv(1);
        sv_w = 1'b0;
        adv(4);
    endtask

    initial begin
        reset_n    = 1'b0;
        step_valid = 1'b0;
        step_left  = 1'b0;
        sv_w       = 1'b0;
        sl_w       = 1'b0;
        #12;
        chk("rst_code", {rotary_b, rotary_a}, 2'b00);
        chk("rst_ready", step_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", step_done, 1'b0);
        chk("rst_pos", position, 16'h0000);
        reset_n = 1'b1;
        adv(2);
        chk("idle_code", {rotary_b, rotary_a}, 2'b00);
        chk("idle_ready", step_ready, 1'b1);

        // Single right step
        ev0 = ev_dir.size();
        step_valid = 1'b1;
        step_left  = 1'b0;
        adv(1);
        step_valid = 1'b0;
        chk("R_ph1", {rotary_b, rotary_a}, 2'b01);
        chk("R_busy", busy, 1'b1);
        chk("R_ready", step_ready, 1'b0);
        chk("R_pos0", position, 16'h0000);
        adv(3);
        chk("R_ph1_end", {rotary_b, rotary_a}, 2'b01);
        chk("R_pos_pre", position, 16'h0000);
        adv(1);
        chk("R_ph2", {rotary_b, rotary_a}, 2'b11);
        chk("R_pos1", position, 16'h0001);
        adv(3);
        chk("R_ph2_end", {rotary_b, rotary_a}, 2'b11);
        adv(1);
        chk("R_ph3", {rotary_b, rotary_a}, 2'b10);
        adv(4);
        chk("R_ph4", {rotary_b, rotary_a}, 2'b00);
        chk("R_ph4_done", step_done, 1'b0);
        chk("R_ph4_busy", busy, 1'b1);
        adv(4);
        chk("R_done", step_done, 1'b1);
        chk("R_done_ready", step_ready, 1'b1);
        chk("R_done_busy", busy, 1'b0);
        chk("R_done_code", {rotary_b, rotary_a}, 2'b00);
        adv(1);
        chk("R_done_pulse", step_done, 1'b0);
        chk("R_events", ev_dir.size() - ev0, 1);
        if (ev_dir.size() > ev0) chk("R_ev_dir", ev_dir[ev0], 1'b0);

        // Asynchronous reset in the middle of PH2
        step_valid = 1'b1;
        step_left  = 1'b0;
        adv(1);
        step_valid = 1'b0;
        adv(5);
        chk("A_ph2", {rotary_b, rotary_a}, 2'b11);
        chk("A_pos", position, 16'h0002);
        #3;
        reset_n = 1'b0;
        #1;
        chk("A_code", {rotary_b, rotary_a}, 2'b00);
        chk("A_pos0", position, 16'h0000);
        chk("A_ready", step_ready, 1'b1);
        chk("A_done", step_done, 1'b0);
        adv(2);
        #2;
        reset_n = 1'b1;
        adv(3);
        chk("A_idle_code", {rotary_b, rotary_a}, 2'b00);
        chk("A_idle_done", step_done, 1'b0);
        chk("A_idle_ready", step_ready, 1'b1);

        // Single left step
        ev0 = ev_dir.size();
        step_valid = 1'b1;
        step_left  = 1'b1;
        adv(1);
        step_valid = 1'b0;
        step_left  = 1'b0;
        chk("L_ph1", {rotary_b, rotary_a}, 2'b10);
        adv(4);
        chk("L_ph2", {rotary_b, rotary_a}, 2'b11);
        chk("L_pos", position, 16'hFFFF);
        adv(4);
        chk("L_ph3", {rotary_b, rotary_a}, 2'b01);
        adv(4);
        chk("L_ph4", {rotary_b, rotary_a}, 2'b00);
        adv(4);
        chk("L_done", step_done, 1'b1);
        adv(1);
        chk("L_events", ev_dir.size() - ev0, 1);
        if (ev_dir.size() > ev0) chk("L_ev_dir", ev_dir[ev0], 1'b1);

        // Back-to-back R, R, L with step_valid held high
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        adv(1);
        ev0 = ev_dir.size();
        acc_cyc.delete();
        acc_dir.delete();
        step_valid = 1'b1;
        step_left  = 1'b0;
        for (int i = 0; i < 100 && acc_cyc.size() < 2; i++) adv(1);
        step_left = 1'b1;
        for (int i = 0; i < 100 && acc_cyc.size() < 3; i++) adv(1);
        step_valid = 1'b0;
        chk("B_accepts", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("B_gap1", acc_cyc[1] - acc_cyc[0], 17);
            chk("B_gap2", acc_cyc[2] - acc_cyc[1], 17);
            chk("B_dir0", acc_dir[0], 1'b0);
            chk("B_dir1", acc_dir[1], 1'b0);
            chk("B_dir2", acc_dir[2], 1'b1);
        end
        adv(16);
        chk("B_done", step_done, 1'b1);
        chk("B_pos", position, 16'h0001);
        chk("B_events", ev_dir.size() - ev0, 3);
        if (ev_dir.size() == ev0 + 3) begin
            chk("B_ev0", ev_dir[ev0], 1'b0);
            chk("B_ev1", ev_dir[ev0 + 1], 1'b0);
            chk("B_ev2", ev_dir[ev0 + 2], 1'b1);
        end
        adv(1);

        // Handshake stall: toggle step_left while busy; direction taken at the accept edge
        acc_cyc.delete();
        acc_dir.delete();
        step_valid = 1'b1;
        step_left  = 1'b0;
        adv(1);
        for (int i = 0; i < 16; i++) begin
            chk("S_ready_low", step_ready, 1'b0);
            step_left = ((i % 2) == 0);
            adv(1);
        end
        chk("S_no_accept", acc_cyc.size(), 1);
        chk("S_ready_high", step_ready, 1'b1);
        step_left = 1'b1;
        adv(1);
        step_valid = 1'b0;
        step_left  = 1'b0;
        chk("S_accepts", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) begin
            chk("S_gap", acc_cyc[1] - acc_cyc[0], 17);
            chk("S_dir", acc_dir[1], 1'b1);
        end
        chk("S_ph1", {rotary_b, rotary_a}, 2'b10);
        adv(16);
        chk("S_done", step_done, 1'b1);
        chk("S_pos", position, 16'h0001);
        adv(1);

        // PHASE_TICKS=1 sequence and position wrap on the 4-bit instance
        sv_w = 1'b1;
        sl_w = 1'b0;
        adv(1);
        sv_w = 1'b0;
        chk("W_ph1", {b_w, a_w}, 2'b01);
        adv(1);
        chk("W_ph2", {b_w, a_w}, 2'b11);
        chk("W_pos1", pos_w, 4'h1);
        adv(1);
        chk("W_ph3", {b_w, a_w}, 2'b10);
        adv(1);
        chk("W_ph4", {b_w, a_w}, 2'b00);
        chk("W_ph4_done", done_w, 1'b0);
        adv(1);
        chk("W_done", done_w, 1'b1);
        chk("W_ready", rdy_w, 1'b1);
        for (int i = 0; i < 6; i++) w_step(1'b0);
        chk("W_pos_max", pos_w, 4'h7);
        w_step(1'b0);
        chk("W_wrap_up", pos_w, 4'h8);
        w_step(1'b1);
        chk("W_wrap_down", pos_w, 4'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
